ws2812_frame_receiver: RTL and testbench
========================================

Name: ws2812_frame_receiver

Overview:
- Decodes the single-wire LED-stripe waveform back into pixel words.
- Measures each high pulse to classify it as 0 or 1, and detects the long constant-level reset sequence (high or low) that ends a frame.
- Used for loopback self-test of the stripe driver, and as the front end of a daisy-chained stripe model in simulation and on board.
- Sits after the pad; asynchronous input.

Parameters:
BITS_PER_PIXEL, 24, bits per pixel word, MSB received first.
BIT1_MIN_CYCLES, 30, high length >= this decodes as 1; below decodes as 0 (0.6 us at 50 MHz).
MIN_HIGH_CYCLES, 5, high length below this is a glitch error.
MAX_HIGH_CYCLES, 60, high length above this (and below RESET_CYCLES) is an error.
RESET_CYCLES, 2500, constant level for this many cycles is a frame reset (50 us).
CNT_W, 12, level-length counter width; must hold RESET_CYCLES.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
led_stripe_in  input  1  asynchronous stripe line
pixel_data  output  BITS_PER_PIXEL  last complete pixel, MSB = first bit received
pixel_valid  output  1  one-cycle pulse; pixel_data/pixel_index valid
pixel_index  output  16  index of pixel within current frame
frame_end  output  1  one-cycle pulse on reset detection
frame_partial  output  1  qualified by frame_end; 1 = leftover bits discarded
bit_error  output  1  one-cycle pulse on malformed high pulse

Behaviour:
Reset:
- Reset is asynchronous and active-low; all regs clear while rstn low: all outputs 0, counters 0, synchronizer flops 0, armed = 0.
- Reset mid-frame discards all partial state.

Input path:
- Two-flop synchronizer s1 -> s2, plus history flop s3.
- rise = s2 & ~s3; fall = ~s2 & s3.

Level counter:
- Loads 1 on rise or fall; otherwise increments; saturates at RESET_CYCLES.
- Length L at fall = cycles s2 was high.

On fall (L < RESET_CYCLES):
- L < MIN_HIGH_CYCLES or L > MAX_HIGH_CYCLES: bit_error pulse; shift register and bit count unchanged.
- Otherwise, bit = (L >= BIT1_MIN_CYCLES).
- Shift left into shift register; bit_cnt++; armed = 1.
- When bit_cnt reaches BITS_PER_PIXEL:
  - pixel_data <= shifted value, pixel_valid = 1, pixel_index = current pixel count.
  - Then pixel count++ and bit_cnt = 0.
- Latency: pixel_valid is high in the 3rd cycle after the first clk edge that samples the line low.

Reset detection (either level):
- Counter reaches RESET_CYCLES while armed:
  - frame_end = 1 for one cycle.
  - frame_partial = (bit_cnt != 0).
  - Clear bit_cnt, shift register, pixel count; armed = 0.
- Fires exactly once per saturation; not again until new valid bit.
- Not armed: saturation is silent (idle line after power-up gives no frame_end).
- High-level reset: the following fall has L saturated; produces no bit and no error.

Other rules:
- pixel_data holds its value until the next pixel_valid; frame_end does not clear it.
- pixel_index wraps 65535 -> 0.
- Low gaps below RESET_CYCLES are not checked; any gap length is accepted between bits.
- Simultaneous events are impossible by construction: reset needs a saturated level, bits need a fall. A fall on the same cycle as saturation still counts as reset only.

Test Plan:
- Reset state: assert rstn low mid-pulse -> all outputs 0; no pulses emerge after release with line idle low for 5000 cycles (not armed).
- Pixel decode: 24 bits of 0xA5_3C_F0, 1 = 40 high / 20 low, 0 = 20 high / 40 low; then 3000 low.
  - -> pixel_valid once, pixel_data = 0xA53CF0, pixel_index = 0.
  - -> frame_end 2500 cycles after last fall, frame_partial = 0.
- Multi-pixel and high-level reset: 3 pixels 0x000001, 0x800000, 0xFFFFFF; line then held high 3000 cycles, then low.
  - -> pixel_index 0, 1, 2; frame_end once when high count reaches 2500; no bit_error; next frame restarts at index 0.
- Thresholds: high lengths 4, 5, 29, 30, 60, 61.
  - -> bit_error; 0; 0; 1; 1; bit_error; bit count advances only for the four valid ones.
- Partial frame: 10 valid bits then 3000 low -> frame_end with frame_partial = 1, no pixel_valid; next 24 bits decode cleanly with index 0.
- Async line jitter: randomize each pulse ±2 cycles around 20/40 and line phase vs clk -> all 64 pixels match the transmitted data; zero bit_error.

Source files
------------

// File: rtl/ws2812_frame_receiver.sv
// Decodes the single-wire LED stripe waveform into pixel words by timing each high pulse;
// a long constant level on the line (either polarity) closes the frame.
module ws2812_frame_receiver #(
  parameter int BITS_PER_PIXEL  = 24,
  parameter int BIT1_MIN_CYCLES = 30,
  parameter int MIN_HIGH_CYCLES = 5,
  parameter int MAX_HIGH_CYCLES = 60,
  parameter int RESET_CYCLES    = 2500,
  parameter int CNT_W           = 12
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      led_stripe_in,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic [15:0]               pixel_index,
  output logic                      frame_end,
  output logic                      frame_partial,
  output logic                      bit_error
);

  localparam int BC_W = $clog2(BITS_PER_PIXEL + 1);
  localparam logic [CNT_W-1:0] RST_LEN  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] MIN_LEN  = CNT_W'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] BIT1_LEN = CNT_W'(BIT1_MIN_CYCLES);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(BITS_PER_PIXEL - 1);

  logic                      s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic [BC_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [15:0]               pix_cnt_q, pix_cnt_d;
  logic                      armed_q, armed_d;
  logic [BITS_PER_PIXEL-1:0] pixel_data_q, pixel_data_d;
  logic                      pixel_valid_q, pixel_valid_d;
  logic [15:0]               pixel_index_q, pixel_index_d;
  logic                      frame_end_q, frame_end_d;
  logic                      frame_partial_q, frame_partial_d;
  logic                      bit_error_q, bit_error_d;
  logic                      rise, fall;

  always_comb begin
    s1_d            = led_stripe_in;
    s2_d            = s1_q;
    s3_d            = s2_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    pix_cnt_d       = pix_cnt_q;
    armed_d         = armed_q;
    pixel_data_d    = pixel_data_q;
    pixel_valid_d   = 1'b0;
    pixel_index_d   = pixel_index_q;
    frame_end_d     = 1'b0;
    frame_partial_d = 1'b0;
    bit_error_d     = 1'b0;

    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;

    // cnt_q at a fall equals the number of cycles the synchronized line was high
    if (rise || fall) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != RST_LEN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A saturated level wins over a coincident fall: that fall carries no bit
    if (cnt_q == RST_LEN) begin
      if (armed_q) begin
        frame_end_d     = 1'b1;
        frame_partial_d = (bit_cnt_q != '0);
        bit_cnt_d       = '0;
        shift_d         = '0;
        pix_cnt_d       = '0;
        armed_d         = 1'b0;
      end
    end else if (fall) begin
      if (cnt_q < MIN_LEN || cnt_q > MAX_LEN) begin
        bit_error_d = 1'b1;
      end else begin
        shift_d = {shift_q[BITS_PER_PIXEL-2:0], (cnt_q >= BIT1_LEN)};
        armed_d = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          pixel_data_d  = shift_d;
          pixel_valid_d = 1'b1;
          pixel_index_d = pix_cnt_q;
          pix_cnt_d     = pix_cnt_q + 16'd1;
          bit_cnt_d     = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      s3_q            <= 1'b0;
      cnt_q           <= '0;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      pix_cnt_q       <= '0;
      armed_q         <= 1'b0;
      pixel_data_q    <= '0;
      pixel_valid_q   <= 1'b0;
      pixel_index_q   <= '0;
      frame_end_q     <= 1'b0;
      frame_partial_q <= 1'b0;
      bit_error_q     <= 1'b0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      s3_q            <= s3_d;
      cnt_q           <= cnt_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      pix_cnt_q       <= pix_cnt_d;
      armed_q         <= armed_d;
      pixel_data_q    <= pixel_data_d;
      pixel_valid_q   <= pixel_valid_d;
      pixel_index_q   <= pixel_index_d;
      frame_end_q     <= frame_end_d;
      frame_partial_q <= frame_partial_d;
      bit_error_q     <= bit_error_d;
    end
  end

  assign pixel_data    = pixel_data_q;
  assign pixel_valid   = pixel_valid_q;
  assign pixel_index   = pixel_index_q;
  assign frame_end     = frame_end_q;
  assign frame_partial = frame_partial_q;
  assign bit_error     = bit_error_q;

endmodule

// File: tb/tb_ws2812_frame_receiver.sv
// Directed bench for ws2812_frame_receiver: drives stripe waveforms and checks decoded
// pixels, frame ends and error pulses against hand-computed values.
module tb_ws2812_frame_receiver;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        line = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [15:0] pixel_index;
  logic        frame_end;
  logic        frame_partial;
  logic        bit_error;

  ws2812_frame_receiver dut (
    .clk           (clk),
    .rstn          (rstn),
    .led_stripe_in (line),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .pixel_index   (pixel_index),
    .frame_end     (frame_end),
    .frame_partial (frame_partial),
    .bit_error     (bit_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event log sampled on the falling edge
  logic [23:0] pix_q[$];
  int          idx_q[$];
  int          pvc_q[$];
  int          fe_cnt = 0;
  int          fe_cyc = 0;
  logic        fe_part = 1'b0;
  int          be_cnt = 0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      pix_q.push_back(pixel_data);
      idx_q.push_back(int'(pixel_index));
      pvc_q.push_back(cyc);
    end
    if (frame_end) begin
      fe_cnt++;
      fe_cyc  = cyc;
      fe_part = frame_partial;
    end
    if (bit_error) be_cnt++;
  end

  int tests = 0;
  int fails = 0;
  int last_fall = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int h, input int l);
    line = 1'b1;
    wait_cyc(h);
    line = 1'b0;
    last_fall = cyc;
    wait_cyc(l);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (w[i]) send_bit(40, 20);
      else      send_bit(20, 40);
    end
  endtask

  task automatic test_pixel_decode();
    int p0, f0, lf;
    p0 = pix_q.size();
    f0 = fe_cnt;
    send_bits(24'hA53CF0, 24);
    lf = last_fall;
    wait_cyc(3000);
    tests++;
    if (pix_q.size() - p0 !== 1) begin
      fails++; $display("FAIL decode_count: got %0d pixels, expected 1", pix_q.size() - p0);
    end
    if (pix_q.size() > p0) begin
      tests++;
      if (pix_q[p0] !== 24'hA53CF0) begin
        fails++; $display("FAIL decode_data: got %h expected a53cf0", pix_q[p0]);
      end
      tests++;
      if (idx_q[p0] !== 0) begin
        fails++; $display("FAIL decode_index: got %0d expected 0", idx_q[p0]);
      end
      tests++;
      if (pvc_q[p0] - lf !== 3) begin
        fails++; $display("FAIL decode_latency: got %0d cycles expected 3", pvc_q[p0] - lf);
      end
    end
    tests++;
    if (fe_cnt - f0 !== 1) begin
      fails++; $display("FAIL decode_frame_end: got %0d expected 1", fe_cnt - f0);
    end
    tests++;
    if (fe_cyc - lf < 2500 || fe_cyc - lf > 2504) begin
      fails++; $display("FAIL decode_fe_time: got %0d cycles expected 2500..2504", fe_cyc - lf);
    end
    tests++;
    if (fe_part !== 1'b0) begin
      fails++; $display("FAIL decode_partial: got %b expected 0", fe_part);
    end
  endtask

  task automatic test_reset();
    int p0, f0, b0;
    send_bits(24'h0002AB, 10);
    line = 1'b1;
    wait_cyc(15);
    rstn = 1'b0;
    #2;
    tests++;
    if ({pixel_data, pixel_valid, pixel_index, frame_end, frame_partial, bit_error} !== 44'd0) begin
      fails++; $display("FAIL reset_outputs: got data=%h vld=%b idx=%0d fe=%b fp=%b be=%b expected all 0",
                        pixel_data, pixel_valid, pixel_index, frame_end, frame_partial, bit_error);
    end
    line = 1'b0;
    wait_cyc(3);
    rstn = 1'b1;
    p0 = pix_q.size();
    f0 = fe_cnt;
    b0 = be_cnt;
    wait_cyc(5000);
    tests++;
    if (fe_cnt - f0 !== 0) begin
      fails++; $display("FAIL reset_idle_frame_end: got %0d expected 0", fe_cnt - f0);
    end
    tests++;
    if (pix_q.size() - p0 !== 0) begin
      fails++; $display("FAIL reset_idle_pixel: got %0d expected 0", pix_q.size() - p0);
    end
    tests++;
    if (be_cnt - b0 !== 0) begin
      fails++; $display("FAIL reset_idle_bit_error: got %0d expected 0", be_cnt - b0);
    end
    tests++;
    if (pixel_data !== 24'h0) begin
      fails++; $display("FAIL reset_pixel_data: got %h expected 000000", pixel_data);
    end
  endtask

  task automatic test_multi_pixel();
    logic [23:0] px[3] = '{24'h000001, 24'h800000, 24'hFFFFFF};
    int p0, f0, b0, hs;
    p0 = pix_q.size();
    f0 = fe_cnt;
    b0 = be_cnt;
    for (int i = 0; i < 3; i++) send_bits(px[i], 24);
    line = 1'b1;
    hs = cyc;
    wait_cyc(3000);
    line = 1'b0;
    wait_cyc(100);
    tests++;
    if (pix_q.size() - p0 !== 3) begin
      fails++; $display("FAIL multi_count: got %0d expected 3", pix_q.size() - p0);
    end
    for (int i = 0; i < 3; i++) begin
      if (pix_q.size() > p0 + i) begin
        tests++;
        if (pix_q[p0+i] !== px[i] || idx_q[p0+i] !== i) begin
          fails++; $display("FAIL multi_pixel%0d: got %h idx %0d expected %h idx %0d",
                            i, pix_q[p0+i], idx_q[p0+i], px[i], i);
        end
      end
    end
    tests++;
    if (fe_cnt - f0 !== 1) begin
      fails++; $display("FAIL multi_frame_end: got %0d expected 1", fe_cnt - f0);
    end
    tests++;
    if (fe_cyc - hs < 2500 || fe_cyc - hs > 2504 || fe_part !== 1'b0) begin
      fails++; $display("FAIL multi_high_reset: got %0d cycles partial %b expected 2500..2504 partial 0",
                        fe_cyc - hs, fe_part);
    end
    tests++;
    if (be_cnt - b0 !== 0) begin
      fails++; $display("FAIL multi_bit_error: got %0d expected 0", be_cnt - b0);
    end
    p0 = pix_q.size();
    send_bits(24'h00C0DE, 24);
    wait_cyc(3000);
    tests++;
    if (pix_q.size() - p0 !== 1 || idx_q[idx_q.size()-1] !== 0 || pix_q[pix_q.size()-1] !== 24'h00C0DE) begin
      fails++; $display("FAIL multi_restart: got n=%0d idx %0d data %h expected n=1 idx 0 data 00c0de",
                        pix_q.size() - p0, idx_q[idx_q.size()-1], pix_q[pix_q.size()-1]);
    end
  endtask

  task automatic test_thresholds();
    int lens[6] = '{4, 5, 29, 30, 60, 61};
    int experr[6] = '{1, 0, 0, 0, 0, 1};
    int b0, p0, f0;
    p0 = pix_q.size();
    f0 = fe_cnt;
    for (int i = 0; i < 6; i++) begin
      b0 = be_cnt;
      send_bit(lens[i], 40);
      tests++;
      if (be_cnt - b0 !== experr[i]) begin
        fails++; $display("FAIL thresh_len%0d: got %0d errors expected %0d", lens[i], be_cnt - b0, experr[i]);
      end
    end
    // valid pulses 5,29,30,60 contribute bits 0,0,1,1 ahead of 20 more bits
    send_bits(24'h0ABCDE, 20);
    wait_cyc(3000);
    tests++;
    if (pix_q.size() - p0 !== 1 || pix_q[pix_q.size()-1] !== 24'h3ABCDE || idx_q[idx_q.size()-1] !== 0) begin
      fails++; $display("FAIL thresh_pixel: got n=%0d data %h idx %0d expected n=1 data 3abcde idx 0",
                        pix_q.size() - p0, pix_q[pix_q.size()-1], idx_q[idx_q.size()-1]);
    end
    tests++;
    if (fe_cnt - f0 !== 1 || fe_part !== 1'b0) begin
      fails++; $display("FAIL thresh_frame_end: got %0d partial %b expected 1 partial 0", fe_cnt - f0, fe_part);
    end
  endtask

  task automatic test_partial();
    int p0, f0;
    p0 = pix_q.size();
    f0 = fe_cnt;
    send_bits(24'h0003A5, 10);
    wait_cyc(3000);
    tests++;
    if (fe_cnt - f0 !== 1 || fe_part !== 1'b1) begin
      fails++; $display("FAIL partial_frame_end: got %0d partial %b expected 1 partial 1", fe_cnt - f0, fe_part);
    end
    tests++;
    if (pix_q.size() - p0 !== 0) begin
      fails++; $display("FAIL partial_no_pixel: got %0d expected 0", pix_q.size() - p0);
    end
    send_bits(24'h5A5A5A, 24);
    wait_cyc(3000);
    tests++;
    if (pix_q.size() - p0 !== 1 || pix_q[pix_q.size()-1] !== 24'h5A5A5A || idx_q[idx_q.size()-1] !== 0) begin
      fails++; $display("FAIL partial_next: got n=%0d data %h idx %0d expected n=1 data 5a5a5a idx 0",
                        pix_q.size() - p0, pix_q[pix_q.size()-1], idx_q[idx_q.size()-1]);
    end
    tests++;
    if (fe_cnt - f0 !== 2 || fe_part !== 1'b0) begin
      fails++; $display("FAIL partial_next_fe: got %0d partial %b expected 2 partial 0", fe_cnt - f0, fe_part);
    end
  endtask

  task automatic test_jitter();
    logic [23:0] tx[64];
    int p0, f0, b0, h, l, base;
    p0 = pix_q.size();
    f0 = fe_cnt;
    b0 = be_cnt;
    for (int i = 0; i < 64; i++) tx[i] = 24'($urandom);
    #($urandom_range(0, 9));
    for (int i = 0; i < 64; i++) begin
      for (int b = 23; b >= 0; b--) begin
        base = tx[i][b] ? 40 : 20;
        h = (base - 2 + int'($urandom_range(0, 4))) * 10 + int'($urandom_range(0, 9));
        l = 20 + int'($urandom_range(0, 19));
        line = 1'b1;
        #(h);
        line = 1'b0;
        #(l);
      end
    end
    @(posedge clk);
    #1;
    wait_cyc(3000);
    tests++;
    if (pix_q.size() - p0 !== 64) begin
      fails++; $display("FAIL jitter_count: got %0d expected 64", pix_q.size() - p0);
    end
    for (int i = 0; i < 64; i++) begin
      if (pix_q.size() > p0 + i) begin
        tests++;
        if (pix_q[p0+i] !== tx[i] || idx_q[p0+i] !== i) begin
          fails++; $display("FAIL jitter_pixel%0d: got %h idx %0d expected %h idx %0d",
                            i, pix_q[p0+i], idx_q[p0+i], tx[i], i);
        end
      end
    end
    tests++;
    if (be_cnt - b0 !== 0) begin
      fails++; $display("FAIL jitter_bit_error: got %0d expected 0", be_cnt - b0);
    end
    tests++;
    if (fe_cnt - f0 !== 1 || fe_part !== 1'b0) begin
      fails++; $display("FAIL jitter_frame_end: got %0d partial %b expected 1 partial 0", fe_cnt - f0, fe_part);
    end
  endtask

  initial begin
    line = 1'b0;
    rstn = 1'b0;
    wait_cyc(5);
    tests++;
    if ({pixel_data, pixel_valid, pixel_index, frame_end, frame_partial, bit_error} !== 44'd0) begin
      fails++; $display("FAIL power_on_reset: got data=%h vld=%b idx=%0d expected all 0",
                        pixel_data, pixel_valid, pixel_index);
    end
    rstn = 1'b1;
    wait_cyc(5);
    test_pixel_decode();
    test_reset();
    test_multi_pixel();
    test_thresholds();
    test_partial();
    test_jitter();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
